// File: rtl/mem_responder.sv
// Single-port memory responder: accepts one read or write at a time and
// completes it with a one-cycle mem_resp pulse LATENCY cycles after acceptance.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        proto_err,
  output logic [15:0] read_count,
  output logic [15:0] write_count
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_ERR} op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [STAT_W-1:0]   rcnt_q, rcnt_d;
  logic [STAT_W-1:0]   wcnt_q, wcnt_d;

  logic [DATA_W-1:0]   mem_array [DEPTH_WORDS];
  logic                mem_we_c;
  logic [DATA_W-1:0]   mem_wword_c;

  // Word offset bits below the index and alias bits above it are don't-care.
  logic unused_addr_c;
  assign unused_addr_c = ^{mem_address[31:IDX_W+2], mem_address[1:0]};

  // Next-state, datapath capture and completion effects.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    resp_d   = 1'b0;
    rdata_d  = '0;
    err_d    = err_q;
    rcnt_d   = rcnt_q;
    wcnt_d   = wcnt_q;
    mem_we_c = 1'b0;

    mem_wword_c = mem_array[idx_q];
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be_q[i]) begin
        mem_wword_c[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (mem_read && mem_write) begin
            op_d  = OP_ERR;
            err_d = 1'b1;
          end else if (mem_read) begin
            op_d = OP_RD;
          end else begin
            op_d = OP_WR;
          end
          idx_d   = mem_address[IDX_W+1:2];
          be_d    = mem_byte_enable;
          wdata_d = mem_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        // Initiator withdrew the request: drop it silently.
        if (!mem_read && !mem_write) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        resp_d  = 1'b1;
        case (op_q)
          OP_RD: begin
            rdata_d = mem_array[idx_q];
            rcnt_d  = rcnt_q + STAT_W'(1);
          end
          OP_WR: begin
            mem_we_c = 1'b1;
            wcnt_d   = wcnt_q + STAT_W'(1);
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Storage is deliberately not reset; a reset forces state out of RESP so no write lands.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_array[idx_q] <= mem_wword_c;
    end
  end

  assign mem_resp    = resp_q;
  assign mem_rdata   = rdata_q;
  assign proto_err   = err_q;
  assign read_count  = rcnt_q;
  assign write_count = wcnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a transaction-level reference model
// compared against the DUT every cycle, plus hand-computed checkpoints.
module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = 4'h0;
  logic [31:0] mem_address = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        proto_err;
  logic [15:0] read_count;
  logic [15:0] write_count;

  int n_tests = 0;
  int n_fail  = 0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .proto_err(proto_err), .read_count(read_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a transaction ages one step per edge; it may be
  // abandoned while younger than LAT and completes on its LAT-th edge.
  logic [31:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  int          age = -1;
  int          m_op = 0;
  int          m_idx = 0;
  logic [3:0]  m_be = 4'h0;
  logic [31:0] m_wd = 32'h0;
  logic        exp_resp = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  bit          exp_known = 1'b1;
  logic        exp_err = 1'b0;
  logic [15:0] exp_rc = 16'h0;
  logic [15:0] exp_wc = 16'h0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age = -1; exp_resp = 1'b0; exp_rdata = 32'h0; exp_known = 1'b1;
      exp_err = 1'b0; exp_rc = 16'h0; exp_wc = 16'h0;
    end else begin
      exp_resp = 1'b0; exp_rdata = 32'h0; exp_known = 1'b1;
      if (age < 0) begin
        if (mem_read || mem_write) begin
          age   = 0;
          m_op  = (mem_read && mem_write) ? 2 : (mem_read ? 0 : 1);
          m_idx = int'((mem_address >> 2) % DEPTH);
          m_be  = mem_byte_enable;
          m_wd  = mem_wdata;
          if (m_op == 2) exp_err = 1'b1;
        end
      end else begin
        age++;
        if (age < int'(LAT)) begin
          if (!mem_read && !mem_write) age = -1;
        end else begin
          exp_resp = 1'b1;
          age = -1;
          if (m_op == 0) begin
            exp_rdata = m_mem[m_idx];
            exp_known = m_val[m_idx];
            exp_rc    = exp_rc + 16'd1;
          end else if (m_op == 1) begin
            for (int b = 0; b < 4; b++)
              if (m_be[b]) m_mem[m_idx][8*b +: 8] = m_wd[8*b +: 8];
            if (m_be == 4'hF) m_val[m_idx] = 1'b1;
            exp_wc = exp_wc + 16'd1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("resp", 32'(mem_resp), 32'(exp_resp));
    if (exp_known) chk("rdata", mem_rdata, exp_rdata);
    chk("proto_err", 32'(proto_err), 32'(exp_err));
    chk("read_count", 32'(read_count), 32'(exp_rc));
    chk("write_count", 32'(write_count), 32'(exp_wc));
  end

  // Drive one request and hold it until mem_resp; lat counts edges after acceptance.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output logic [31:0] rdata, output int lat);
    int cyc;
    bit got;
    cyc = 0; got = 1'b0;
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = data; mem_byte_enable = be;
    while (!got && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_resp) got = 1'b1;
    end
    rdata = mem_rdata;
    lat = cyc - 1;
    mem_read = 1'b0; mem_write = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL txn_timeout: got no resp expected resp for addr %h", addr);
    end
  endtask

  task automatic idle_cycles(input int n, output int resps);
    resps = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (mem_resp) resps++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, nr, first_r, last_r;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp", 32'(mem_resp), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_err", 32'(proto_err), 32'h0);
    chk("rst_rc", 32'(read_count), 32'h0);
    chk("rst_wc", 32'(write_count), 32'h0);
    rst = 1'b1;

    // Full write then immediate read-after-write.
    do_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_count1", 32'(write_count), 32'd1);
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_deadbeef", rd, 32'hDEAD_BEEF);
    chk("rd_count1", 32'(read_count), 32'd1);

    // Partial lane write, then an all-lanes-disabled write.
    do_txn(1'b0, 1'b1, 32'h0000_0013, 32'h0000_AA00, 4'b0010, rd, lat);
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, lat);
    chk("rd_partial", rd, 32'hDEAD_AAEF);
    do_txn(1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, rd, lat);
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, lat);
    chk("rd_be0", rd, 32'hDEAD_AAEF);
    chk("wc_be0", 32'(write_count), 32'd3);

    // Abort in the first busy cycle.
    do_txn(1'b0, 1'b1, 32'h0000_0020, 32'h55AA_55AA, 4'hF, rd, lat);
    mem_write = 1'b1; mem_address = 32'h0000_0020; mem_wdata = 32'h1234_5678;
    mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    mem_write = 1'b0; mem_address = 32'h0000_0FFC; mem_wdata = 32'h0;
    idle_cycles(8, nr);
    chk("abort_no_resp", 32'(nr), 32'd0);
    do_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, rd, lat);
    chk("abort_rd", rd, 32'h55AA_55AA);
    chk("abort_wc", 32'(write_count), 32'd4);

    // Aliasing, then reads held high across responses.
    do_txn(1'b0, 1'b1, 32'h0000_1004, 32'h1111_1111, 4'hF, rd, lat);
    do_txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, rd, lat);
    chk("alias_rd", rd, 32'h1111_1111);
    mem_read = 1'b1; mem_address = 32'h0000_0004;
    nr = 0; first_r = 0; last_r = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        nr++;
        if (first_r == 0) first_r = i;
        last_r = i;
      end
    end
    mem_read = 1'b0;
    chk("held_resps", 32'(nr), 32'd5);
    chk("held_first", 32'(first_r), 32'd4);
    chk("held_last", 32'(last_r), 32'd20);
    chk("held_rc", 32'(read_count), 32'd10);

    // Read and write together.
    do_txn(1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, rd, lat);
    chk("err_lat", 32'(lat), 32'd3);
    chk("err_rdata", rd, 32'h0);
    chk("err_flag", 32'(proto_err), 32'h1);
    chk("err_rc", 32'(read_count), 32'd10);
    chk("err_wc", 32'(write_count), 32'd5);
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, lat);
    chk("err_no_write", rd, 32'hDEAD_AAEF);
    chk("err_sticky", 32'(proto_err), 32'h1);

    // Reset during a busy write.
    do_txn(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'hF, rd, lat);
    mem_write = 1'b1; mem_address = 32'h0000_0040; mem_wdata = 32'hCAFE_F00D;
    mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; mem_write = 1'b0;
    #1;
    chk("arst_resp", 32'(mem_resp), 32'h0);
    chk("arst_err", 32'(proto_err), 32'h0);
    chk("arst_rc", 32'(read_count), 32'h0);
    chk("arst_wc", 32'(write_count), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(6, nr);
    chk("arst_no_resp", 32'(nr), 32'd0);
    do_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, rd, lat);
    chk("arst_rd", rd, 32'h0);
    chk("arst_rc1", 32'(read_count), 32'd1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal array; power of two, minimum 4.
REQ-002 Parameter LATENCY, default 3, cycles from request acceptance to mem_resp; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserting it (low) clears state immediately, deassertion is synchronous to clk.
REQ-005 mem_read  input  1  read request from the initiator, held high until mem_resp.
REQ-006 mem_write  input  1  write request from the initiator, held high until mem_resp.
REQ-007 mem_byte_enable  input  4  write byte lanes; bit i enables mem_wdata[8i+7:8i].
REQ-008 mem_address  input  32  byte address; bits [1:0] ignored.
REQ-009 mem_wdata  input  32  write data.
REQ-010 mem_resp  output  1  single-cycle completion pulse.
REQ-011 mem_rdata  output  32  read data, valid only in the mem_resp cycle.
REQ-012 proto_err  output  1  sticky protocol-error flag.
REQ-013 read_count  output  16  completed reads, wraps at 65535 -> 0.
REQ-014 write_count  output  16  completed writes, wraps at 65535 -> 0.

Function
REQ-015 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-016 IDLE: if mem_read or mem_write is high, latch opcode, word index, byte enables and wdata, load latency counter with LATENCY-1, go to BUSY (or directly to RESP when LATENCY=1).
REQ-017 BUSY: decrement counter; at zero go to RESP; mem_resp rises exactly LATENCY cycles after the accepting IDLE edge.
REQ-018 BUSY abort: if both mem_read and mem_write are low in any BUSY cycle, return to IDLE, no array update, no mem_resp, no counter change.
REQ-019 RESP: mem_resp=1 for exactly one cycle, then unconditionally IDLE; a request still high in the following IDLE cycle is treated as a new request.
REQ-020 Word index = mem_address[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing wrap-around).
REQ-021 Read: mem_rdata = array[index] during RESP; mem_rdata = 0 in all other cycles.
REQ-022 Write: on the RESP clock edge, update only enabled byte lanes of array[index]; byte_enable=0000 completes normally with no data change.
REQ-023 Read-after-write to the same index issued on the cycle after RESP returns the newly written data.
REQ-024 mem_read and mem_write both high at acceptance: set proto_err, perform no array access, still complete with mem_resp after LATENCY, mem_rdata=0, neither count increments.
REQ-025 Address, wdata or byte-enable changes during BUSY are ignored; latched values are used.
REQ-026 read_count/write_count increment on the RESP edge of a completed read/write respectively.
REQ-027 Outputs are registered; no combinational path from inputs to mem_resp or mem_rdata.

Reset
REQ-028 On rst low: state IDLE, mem_resp=0, mem_rdata=0, proto_err=0, read_count=0, write_count=0, latency counter=0.
REQ-029 Reset mid-transaction (BUSY or RESP) discards the transaction; no array write occurs and no mem_resp is produced.
REQ-030 Array contents are not cleared by reset and are undefined until written.

Verification
REQ-031 LATENCY=3: write 0xDEADBEEF to 0x0000_0010, be=1111 -> mem_resp 3 cycles after acceptance, write_count=1; then read 0x10 -> mem_rdata=0xDEADBEEF in resp cycle, read_count=1.
REQ-032 Partial write: after REQ-031, write 0x0000_AA00 be=0010 to 0x13 -> read 0x10 returns 0xDEADAAEF.
REQ-033 Abort: start write of 0x12345678 to 0x20, drop mem_write in BUSY cycle 1 -> no mem_resp; later read 0x20 returns previous contents; write_count unchanged.
REQ-034 Both mem_read and mem_write high -> proto_err=1 and stays 1, mem_resp after LATENCY, mem_rdata=0, counts unchanged.
REQ-035 Reset low during BUSY of write 0xCAFEF00D to 0x40 -> all outputs 0 immediately, no mem_resp; read 0x40 after reset does not return 0xCAFEF00D (given prior write 0x0 there).
REQ-036 Aliasing with DEPTH_WORDS=1024: write 0x11111111 to 0x0000_1004, read 0x0000_0004 -> 0x11111111; back-to-back reads with request held through resp produce one resp per LATENCY+1 cycles.
